vend_arbiter: RTL and testbench

- Shares one vending_machine core between NUM_PANELS customer front panels.
- Grants the core to one panel at a time, round-robin.
- Forwards that panel's item select, coins and cancel to the core, then returns the dispense or refund result to the owning panel only.
- Adds an inactivity timeout that auto-cancels abandoned sessions. It sits between the panel I/O logic and the vending_machine instance.

---
 rtl/vend_pkg.sv | 35 +++
 rtl/vend_rr_pick.sv | 40 ++++
 rtl/vend_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_vend_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-core arbiter.
//   - 3-bit state encoding of the session FSM
//   - datapath widths (item select, money, stock, internal credit)
//   - saturating credit arithmetic helpers
package vend_pkg;

  localparam int ITEM_W    = 2;
  localparam int MONEY_W   = 8;
  localparam int STOCK_W   = 4;
  localparam int NUM_ITEMS = 4;
  localparam int CREDIT_W  = MONEY_W + 1;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_SELECT      = 3'd1;
  localparam logic [2:0] ST_CHECK       = 3'd2;
  localparam logic [2:0] ST_COLLECT     = 3'd3;
  localparam logic [2:0] ST_WAIT_RESULT = 3'd4;
  localparam logic [2:0] ST_CANCEL      = 3'd5;
  localparam logic [2:0] ST_DONE        = 3'd6;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(255);

  // credit + coin, saturating at 255 (the 9th bit only holds the carry)
  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CREDIT_W-1:0] credit,
                                                     input logic [MONEY_W-1:0]  coin);
    logic [CREDIT_W-1:0] sum;
    sum = credit + {1'b0, coin};
    return (sum > CREDIT_MAX) ? CREDIT_MAX : sum;
  endfunction

  function automatic logic [MONEY_W-1:0] clamp_money(input logic [CREDIT_W-1:0] credit);
    return (credit > CREDIT_MAX) ? MONEY_W'(255) : credit[MONEY_W-1:0];
  endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin first-one finder.
//   i_req   : request vector
//   i_ptr   : index where the search starts (wraps around)
//   o_grant : one-hot of the first requester at or after i_ptr
//   o_idx   : binary index of that requester
//   o_found : at least one request present
module vend_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  function automatic int wrap_idx(input int base, input int k);
    int j;
    j = base + k;
    if (j >= N) j = j - N;
    return j;
  endfunction

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_req[wrap_idx(int'(i_ptr), k)]) begin
        o_found                              = 1'b1;
        o_grant[wrap_idx(int'(i_ptr), k)]    = 1'b1;
        o_idx                                = PW'(wrap_idx(int'(i_ptr), k));
      end
    end
  end

endmodule

// File: rtl/vend_arbiter.sv
// Shares one vending_machine core between NUM_PANELS front panels.
// One panel owns the core per session (round-robin), its select/coins/cancel
// are forwarded, and the result is returned to that panel only. Abandoned
// sessions are auto-cancelled by an idle timer and a result-wait timer.
//   clk, reset_n                      : clock, async active-low reset
//   p_req/p_item/p_coin/p_cancel      : per-panel inputs (panel i in lane i)
//   p_grant/p_done                    : one-hot owner / end-of-session pulse
//   p_dispensed/p_change              : session result, valid with p_done
//   vm_item_select/vm_money_in/vm_cancel : to the core
//   vm_dispense/vm_change/vm_money_needed/vm_stock : from the core
//   busy                              : FSM not idle
module vend_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_PANELS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RESULT_WAIT    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PANELS-1:0]        p_req,
  input  logic [ITEM_W*NUM_PANELS-1:0] p_item,
  input  logic [MONEY_W*NUM_PANELS-1:0] p_coin,
  input  logic [NUM_PANELS-1:0]        p_cancel,
  output logic [NUM_PANELS-1:0]        p_grant,
  output logic [NUM_PANELS-1:0]        p_done,
  output logic                         p_dispensed,
  output logic [MONEY_W-1:0]           p_change,
  output logic [ITEM_W-1:0]            vm_item_select,
  output logic [MONEY_W-1:0]           vm_money_in,
  output logic                         vm_cancel,
  input  logic                         vm_dispense,
  input  logic [MONEY_W-1:0]           vm_change,
  input  logic [MONEY_W-1:0]           vm_money_needed,
  input  logic [STOCK_W-1:0]           vm_stock,
  output logic                         busy
);

  localparam int PW = $clog2(NUM_PANELS);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int WW = $clog2(RESULT_WAIT) + 1;
  localparam logic [PW-1:0] LAST_PANEL = PW'(NUM_PANELS - 1);

  logic [2:0]            r_state, w_state_nxt;
  logic [PW-1:0]         r_owner, r_rr_ptr;
  logic [NUM_PANELS-1:0] r_grant;
  logic [ITEM_W-1:0]     r_item;
  logic [MONEY_W-1:0]    r_money_in, r_change;
  logic [CREDIT_W-1:0]   r_credit;
  logic [TW-1:0]         r_idle_tmr;
  logic [WW-1:0]         r_wait_tmr;
  logic                  r_cancel_cnt, r_coin_seen, r_dispensed;

  logic [NUM_PANELS-1:0] w_pick_grant;
  logic [PW-1:0]         w_pick_idx;
  logic                  w_pick_found;
  logic [MONEY_W-1:0]    w_own_coin;
  logic                  w_own_abort, w_accept_coin;

  vend_rr_pick #(.N(NUM_PANELS), .PW(PW)) u_pick (
    .i_req   (p_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Owner lane selection; other panels' inputs never reach the core.
  assign w_own_coin  = p_coin[MONEY_W*int'(r_owner) +: MONEY_W];
  assign w_own_abort = p_cancel[r_owner] | ~p_req[r_owner];
  // A coin is taken only on cycles where the session stays in COLLECT, so a
  // coin arriving with cancel, dispense or full payment is neither forwarded
  // nor credited.
  assign w_accept_coin = (r_state == ST_COLLECT) && (w_state_nxt == ST_COLLECT);

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_found) w_state_nxt = ST_SELECT;
      ST_SELECT: w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = (vm_stock == '0) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: begin
        if (vm_dispense)                                 w_state_nxt = ST_DONE;
        else if (w_own_abort)                            w_state_nxt = ST_CANCEL;
        else if (r_coin_seen && vm_money_needed == '0)   w_state_nxt = ST_WAIT_RESULT;
        else if (w_own_coin == '0 &&
                 r_idle_tmr == TW'(TIMEOUT_CYCLES - 1))  w_state_nxt = ST_CANCEL;
      end
      ST_WAIT_RESULT: begin
        if (vm_dispense)                               w_state_nxt = ST_DONE;
        else if (r_wait_tmr == WW'(RESULT_WAIT - 1))   w_state_nxt = ST_CANCEL;
      end
      ST_CANCEL: if (r_cancel_cnt) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- session datapath ----------------
  // NOTE: every register here is reset; there is no storage array, so the
  // whole session context is cleared asynchronously and no refund survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_item       <= '0;
      r_money_in   <= '0;
      r_change     <= '0;
      r_credit     <= '0;
      r_idle_tmr   <= '0;
      r_wait_tmr   <= '0;
      r_cancel_cnt <= 1'b0;
      r_coin_seen  <= 1'b0;
      r_dispensed  <= 1'b0;
    end else begin
      r_money_in <= w_accept_coin ? w_own_coin : '0;
      if (w_accept_coin) begin
        r_credit   <= sat_credit(r_credit, w_own_coin);
        r_idle_tmr <= (w_own_coin != '0) ? '0 : r_idle_tmr + TW'(1);
        if (w_own_coin != '0) r_coin_seen <= 1'b1;
      end
      case (r_state)
        ST_IDLE: if (w_pick_found) begin
          r_owner <= w_pick_idx;
          r_grant <= w_pick_grant;
          r_item  <= p_item[ITEM_W*int'(w_pick_idx) +: ITEM_W];
        end
        ST_CHECK: begin
          r_dispensed <= 1'b0;
          r_change    <= '0;
        end
        ST_COLLECT, ST_WAIT_RESULT: begin
          if (vm_dispense) begin
            r_dispensed <= 1'b1;
            r_change    <= vm_change;
          end
          if (r_state == ST_WAIT_RESULT) r_wait_tmr <= r_wait_tmr + WW'(1);
        end
        ST_CANCEL: begin
          r_cancel_cnt <= ~r_cancel_cnt;
          r_dispensed  <= 1'b0;
          r_change     <= clamp_money(r_credit);
        end
        ST_DONE: begin
          r_grant      <= '0;
          r_item       <= '0;
          r_credit     <= '0;
          r_idle_tmr   <= '0;
          r_wait_tmr   <= '0;
          r_cancel_cnt <= 1'b0;
          r_coin_seen  <= 1'b0;
          r_dispensed  <= 1'b0;
          r_change     <= '0;
          r_rr_ptr     <= (r_owner == LAST_PANEL) ? '0 : r_owner + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign p_grant        = r_grant;
  assign vm_item_select = r_item;
  assign vm_money_in    = r_money_in;

  always_comb begin
    p_done      = '0;
    p_dispensed = 1'b0;
    p_change    = '0;
    vm_cancel   = 1'b0;
    busy        = (r_state != ST_IDLE);
    if (r_state == ST_DONE) begin
      p_done      = r_grant;
      p_dispensed = r_dispensed;
      p_change    = r_change;
    end
    if (r_state == ST_CANCEL) vm_cancel = 1'b1;
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed self-checking bench for vend_arbiter (4 panels, default timers).
module tb_vend_arbiter;
  import vend_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   p_req = '0, p_cancel = '0;
  logic [2*N-1:0] p_item = '0;
  logic [8*N-1:0] p_coin = '0;
  logic [N-1:0]   p_grant, p_done;
  logic           p_dispensed, vm_cancel, busy;
  logic [7:0]     p_change, vm_money_in;
  logic [1:0]     vm_item_select;
  logic           vm_dispense = 1'b0;
  logic [7:0]     vm_change = '0, vm_money_needed = '0;
  logic [3:0]     vm_stock = '0;

  int n_checks = 0;
  int n_errors = 0;

  vend_arbiter #(.NUM_PANELS(N), .TIMEOUT_CYCLES(64), .RESULT_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_req(p_req), .p_item(p_item), .p_coin(p_coin), .p_cancel(p_cancel),
    .p_grant(p_grant), .p_done(p_done), .p_dispensed(p_dispensed), .p_change(p_change),
    .vm_item_select(vm_item_select), .vm_money_in(vm_money_in), .vm_cancel(vm_cancel),
    .vm_dispense(vm_dispense), .vm_change(vm_change), .vm_money_needed(vm_money_needed),
    .vm_stock(vm_stock), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input int p, input logic [1:0] v);
    p_item[2*p +: 2] = v;
  endtask

  task automatic set_coin(input int p, input logic [7:0] v);
    p_coin[8*p +: 8] = v;
  endtask

  // Request from panel p for item it and walk IDLE->SELECT->CHECK->COLLECT.
  task automatic open_session(input int p, input logic [1:0] it, input logic [7:0] price);
    p_req = '0;
    p_req[p] = 1'b1;
    set_item(p, it);
    vm_stock = 4'd5;
    vm_money_needed = price;
    repeat (3) tick();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  item;
    logic [31:0] coin;
    logic [7:0]  needed;
    logic        disp;
    logic [7:0]  vchg;
    logic [3:0]  e_grant;
    logic [3:0]  e_done;
    logic        e_disp;
    logic [7:0]  e_chg;
    logic [7:0]  e_money;
    logic [1:0]  e_item;
    logic        e_busy;
  } vec_t;

  vec_t vecs[9];
  bit   money_seen;
  bit   p2_done_seen;
  int   cancel_cycles;

  initial begin
    // Panel 0 buys item 1 (price 35) with 20 + 15; stock is 5 throughout.
    //           req      item   coin    need   d   vchg  grant    done     ed  echg  money  item busy
    vecs[0] = '{4'b0001, 8'h01, 32'd0,  8'd35, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[1] = '{4'b0001, 8'h01, 32'd0,  8'd35, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[2] = '{4'b0001, 8'h01, 32'd0,  8'd35, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[3] = '{4'b0001, 8'h01, 32'd20, 8'd35, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd20, 2'd1, 1'b1};
    vecs[4] = '{4'b0001, 8'h01, 32'd0,  8'd35, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[5] = '{4'b0001, 8'h01, 32'd15, 8'd15, 1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd15, 2'd1, 1'b1};
    vecs[6] = '{4'b0001, 8'h01, 32'd0,  8'd0,  1'b0, 8'd0, 4'b0001, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[7] = '{4'b0001, 8'h01, 32'd0,  8'd0,  1'b1, 8'd0, 4'b0001, 4'b0001, 1'b1, 8'd0, 8'd0,  2'd1, 1'b1};
    vecs[8] = '{4'b0000, 8'h01, 32'd0,  8'd0,  1'b0, 8'd0, 4'b0000, 4'b0000, 1'b0, 8'd0, 8'd0,  2'd0, 1'b0};

    // ---------- reset state ----------
    #3;
    check("rst grant", 32'(p_grant), 0);
    check("rst done", 32'(p_done), 0);
    check("rst disp", 32'(p_dispensed), 0);
    check("rst change", 32'(p_change), 0);
    check("rst item", 32'(vm_item_select), 0);
    check("rst money", 32'(vm_money_in), 0);
    check("rst vmcancel", 32'(vm_cancel), 0);
    check("rst busy", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    vm_stock = 4'd5;

    // ---------- table: panel 0 purchase ----------
    for (int i = 0; i < 9; i++) begin
      p_req = vecs[i].req;
      p_item = vecs[i].item;
      p_coin = vecs[i].coin;
      vm_money_needed = vecs[i].needed;
      vm_dispense = vecs[i].disp;
      vm_change = vecs[i].vchg;
      tick();
      check($sformatf("v%0d grant", i), 32'(p_grant), 32'(vecs[i].e_grant));
      check($sformatf("v%0d done", i), 32'(p_done), 32'(vecs[i].e_done));
      check($sformatf("v%0d disp", i), 32'(p_dispensed), 32'(vecs[i].e_disp));
      check($sformatf("v%0d change", i), 32'(p_change), 32'(vecs[i].e_chg));
      check($sformatf("v%0d money", i), 32'(vm_money_in), 32'(vecs[i].e_money));
      check($sformatf("v%0d item", i), 32'(vm_item_select), 32'(vecs[i].e_item));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d vmcancel", i), 32'(vm_cancel), 0);
    end
    vm_dispense = 1'b0;

    // ---------- panels 1 and 2 together from reset ----------
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    p_item = '0;
    set_item(2, 2'd2);
    vm_stock = 4'd0;
    p_req = 4'b0110;
    p2_done_seen = 1'b0;
    tick();
    check("rr first grant", 32'(p_grant), 32'b0010);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (p_done[2]) p2_done_seen = 1'b1;
    end
    check("rr p1 done", 32'(p_done), 32'b0010);
    check("rr p2 no done", 32'(p2_done_seen), 0);
    p_req = 4'b0100;
    tick();
    check("rr ptr after p1", 32'(dut.r_rr_ptr), 2);
    tick();
    check("rr second grant", 32'(p_grant), 32'b0100);
    check("rr second item", 32'(vm_item_select), 2);
    repeat (2) tick();
    check("rr p2 done", 32'(p_done), 32'b0100);
    p_req = '0;
    tick();
    check("rr ptr after p2", 32'(dut.r_rr_ptr), 3);

    // ---------- panel 3 cancel with credit 30, non-owner noise ----------
    open_session(3, 2'd2, 8'd50);
    check("c grant", 32'(p_grant), 32'b1000);
    set_coin(3, 8'd30);
    set_coin(0, 8'd99);
    p_cancel[0] = 1'b1;
    tick();
    check("c money 30", 32'(vm_money_in), 30);
    set_coin(3, 8'd0);
    vm_money_needed = 8'd20;
    tick();
    check("c busy collect", 32'(busy), 1);
    set_coin(3, 8'd7);
    p_cancel[3] = 1'b1;
    cancel_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      p_cancel[3] = 1'b0;
      set_coin(3, 8'd0);
      if (vm_cancel) cancel_cycles++;
      if (c == 0) check("c coin dropped", 32'(vm_money_in), 0);
      if (p_done != '0) break;
    end
    check("c vmcancel cycles", 32'(cancel_cycles), 2);
    check("c done", 32'(p_done), 32'b1000);
    check("c disp", 32'(p_dispensed), 0);
    check("c refund", 32'(p_change), 30);
    p_req = '0;
    p_cancel = '0;
    p_coin = '0;
    tick();
    check("c credit cleared", 32'(dut.r_credit), 0);
    check("c idle", 32'(busy), 0);

    // ---------- sold out ----------
    p_req = 4'b0001;
    set_item(0, 2'd3);
    vm_stock = 4'd0;
    money_seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (vm_money_in != 0) money_seen = 1'b1;
    end
    check("so not done at check", 32'(p_done), 0);
    tick();
    if (vm_money_in != 0) money_seen = 1'b1;
    check("so done", 32'(p_done), 32'b0001);
    check("so disp", 32'(p_dispensed), 0);
    check("so change", 32'(p_change), 0);
    check("so money quiet", 32'(money_seen), 0);
    p_req = '0;
    tick();

    // ---------- panel 1 item 3 paid 50, change 5; p_item change ignored ----------
    open_session(1, 2'd3, 8'd45);
    set_item(1, 2'd0);
    set_coin(1, 8'd50);
    tick();
    check("b5 money 50", 32'(vm_money_in), 50);
    check("b5 item frozen", 32'(vm_item_select), 3);
    set_coin(1, 8'd0);
    vm_money_needed = 8'd0;
    tick();
    check("b5 money wait", 32'(vm_money_in), 0);
    vm_dispense = 1'b1;
    vm_change = 8'd5;
    tick();
    vm_dispense = 1'b0;
    check("b5 done", 32'(p_done), 32'b0010);
    check("b5 disp", 32'(p_dispensed), 1);
    check("b5 change", 32'(p_change), 5);
    p_req = '0;
    tick();

    // ---------- panel 2: no dispense within RESULT_WAIT ----------
    open_session(2, 2'd1, 8'd35);
    set_coin(2, 8'd40);
    tick();
    set_coin(2, 8'd0);
    vm_money_needed = 8'd0;
    tick();
    repeat (3) tick();
    check("rw no cancel yet", 32'(vm_cancel), 0);
    tick();
    check("rw cancel", 32'(vm_cancel), 1);
    repeat (2) tick();
    check("rw done", 32'(p_done), 32'b0100);
    check("rw refund", 32'(p_change), 40);
    check("rw disp", 32'(p_dispensed), 0);
    p_req = '0;
    tick();

    // ---------- panel 3: idle timeout after 10 inserted ----------
    open_session(3, 2'd1, 8'd35);
    set_coin(3, 8'd10);
    tick();
    set_coin(3, 8'd0);
    vm_money_needed = 8'd25;
    repeat (63) tick();
    check("to no cancel yet", 32'(vm_cancel), 0);
    check("to still busy", 32'(busy), 1);
    tick();
    check("to cancel", 32'(vm_cancel), 1);
    repeat (2) tick();
    check("to done", 32'(p_done), 32'b1000);
    check("to refund", 32'(p_change), 10);
    p_req = '0;
    tick();

    // ---------- async reset mid-COLLECT ----------
    open_session(0, 2'd2, 8'd50);
    set_coin(0, 8'd25);
    tick();
    set_coin(0, 8'd0);
    check("ar money before", 32'(vm_money_in), 25);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar grant", 32'(p_grant), 0);
    check("ar money", 32'(vm_money_in), 0);
    check("ar item", 32'(vm_item_select), 0);
    check("ar busy", 32'(busy), 0);
    check("ar done", 32'(p_done), 0);
    check("ar change", 32'(p_change), 0);
    p_req = '0;
    #2;
    reset_n = 1'b1;
    #1;
    check("ar state idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("ar rr ptr", 32'(dut.r_rr_ptr), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
